rv_icache: RTL and testbench
============================

// Module: rv_icache
// PURPOSE
//  Direct-mapped instruction cache between rv_core instr port and w25q_spi flash fetch unit.
//  Hides SPI flash latency for loops/repeated code; read-only, one 32-bit word per line.
//  Core-side and memory-side use same req/rvalid protocol as core instr interface.
// PARAMETERS
//  LINES      64   number of cache lines; power of 2, >=2; IDX=$clog2(LINES), TAG=XLEN-2-IDX
// PORTS
//  clk_i           in   1     clock
//  arst_i          in   1     reset, asynchronous, active-high
//  flush_i         in   1     invalidate all lines (fence.i), single-cycle pulse
//  instr_req_i     in   1     core fetch request; held with stable addr until rvalid
//  instr_addr_i    in   XLEN  fetch byte address; bits [1:0] ignored
//  instr_rvalid_o  out  1     one-cycle pulse, fetched word valid
//  instr_rdata_o   out  XLEN  fetched word
//  mem_req_o       out  1     refill request to flash unit; held until mem_rvalid_i
//  mem_addr_o      out  XLEN  word-aligned refill address (held stable with req)
//  mem_rvalid_i    in   1     refill data valid pulse
//  mem_rdata_i     in   XLEN  refill data
// BEHAVIOUR
//  Reset: state IDLE, all valid bits 0, instr_rvalid_o=0, instr_rdata_o=0, mem_req_o=0, mem_addr_o=0.
//  Address split: idx=addr[IDX+1:2], tag=addr[XLEN-1:IDX+2].
//  FSM (icache_state_t): IDLE, LOOKUP, REFILL, RESP, PREFETCH (macro only).
//   IDLE: instr_req_i sampled at edge T -> latch addr, sync-read tag/valid/data -> LOOKUP.
//   LOOKUP: hit (valid & tag eq) -> instr_rvalid_o=1 at T+2 with line data -> IDLE.
//           miss -> mem_req_o=1, mem_addr_o={addr[XLEN-1:2],2'b00} registered -> REFILL.
//   REFILL: wait mem_rvalid_i; on that edge write line (data,tag,valid=1), capture data,
//           clear mem_req_o (low in following cycle) -> RESP.
//   RESP: instr_rvalid_o=1 one cycle with captured data -> IDLE (or PREFETCH, see macro).
//  Hit latency 2 cycles; miss latency = flash latency + 2. No new req accepted outside IDLE.
//  instr_rvalid_o is registered, exactly one pulse per accepted request; rdata holds last value.
//  Downstream contract: flash unit starts a new transaction only on req seen high after its rvalid.
//  Flush: clears all valid bits on the sampling edge.
//   flush_i with req in IDLE: flush first; the req is a miss.
//   flush_i during LOOKUP: treat lookup as miss.
//   flush_i during REFILL/PREFETCH: transaction completes; returned word still goes to core
//   (REFILL) but line is NOT written (valid stays 0).
//  Address wrap: prefetch addr = addr+4 modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000).
//  arst_i mid-operation: immediate return to reset values; outstanding refill abandoned
//  (flash unit shares same reset).
// CONFIGURATION
//  RV_ICACHE_PREFETCH_EN defined: after RESP of a miss, enter PREFETCH: issue mem_req_o for
//   addr+4, write that line on mem_rvalid_i (unless flushed), no core response; then IDLE.
//   Core req arriving in PREFETCH is held until return to IDLE. Hits never trigger prefetch.
//  Not defined: RESP -> IDLE directly; PREFETCH state absent; refill only on demand miss.
// STRUCTURE
//  rv_pkg: typedef enum icache_state_t; localparam ICACHE_LINES_DEFAULT=64.
//  Sub-module rv_icache_mem: valid bit vector (flash-clearable, async reset) + tag/data arrays,
//   sync read, single write port; FSM, address latch and mem interface in rv_icache.
//  rv_fpga_soc: core instr port -> rv_icache -> w25q_spi (ADDRESS_DEC_LT subtraction stays at soc).
// TESTING
//  1. Reset asserted mid-REFILL -> all outputs 0 next cycle; after release req 0x100 is a miss.
//  2. Cold req 0x0000_0100, flash returns 0x1234_5678 after 5 cycles -> rvalid pulse with
//     0x1234_5678 at 7 cycles; repeat 0x100 -> rvalid at T+2, mem_req_o stays 0.
//  3. LINES=64: fetch 0x100, then 0x200 (same idx 0), then 0x100 -> three misses, 3 mem_reqs.
//  4. Fetch 0x100, pulse flush_i, fetch 0x100 -> miss; flush_i during REFILL of 0x104 -> core
//     receives data, next fetch 0x104 misses.
//  5. Macro on: miss 0x100 -> mem_req 0x104 follows rvalid; then req 0x104 -> hit, no mem_req;
//     miss 0xFFFF_FFFC -> prefetch of 0x0000_0000. Macro off: req 0x104 misses.
//  6. Back-to-back hits 0x100,0x104,0x108 -> one rvalid per req, each 2 cycles after acceptance.

Source files
------------

// File: rtl/rv_icache_pkg.sv
// rtl/rv_icache_pkg.sv - shared types and constants for the rv_icache instruction cache
// Optional feature macro: RV_ICACHE_PREFETCH_EN (adds the PREFETCH state).
package rv_icache_pkg;

    localparam int XLEN                 = 32;
    localparam int ICACHE_LINES_DEFAULT = 64;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOOKUP   = 3'd1,
        REFILL   = 3'd2,
        RESP     = 3'd3
`ifdef RV_ICACHE_PREFETCH_EN
        ,
        PREFETCH = 3'd4
`endif
    } icache_state_t;

endpackage

// File: rtl/rv_icache_if.sv
// rtl/rv_icache_if.sv - req/rvalid fetch bus shared by the core side and the flash side
// Signals: req (held until rvalid), addr (stable with req), rvalid (one-cycle pulse), rdata.
// master drives req/addr, slave drives rvalid/rdata.
interface rv_icache_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, output addr, input rvalid, input rdata);
    modport slave  (input req, input addr, output rvalid, output rdata);
endinterface

// File: rtl/rv_icache_mem.sv
// rtl/rv_icache_mem.sv - valid/tag/data storage for rv_icache, synchronous read, one write port
// Ports: clk_i, arst_i (async, active-high), flush_i (clear all valid bits),
//        rd_idx_i -> rd_valid_o/rd_tag_o/rd_data_o (registered, one cycle later),
//        wr_en_i/wr_idx_i/wr_tag_i/wr_data_i (line write, sets valid).
module rv_icache_mem
    import rv_icache_pkg::*;
#(
    parameter int LINES = ICACHE_LINES_DEFAULT,
    parameter int IDX   = $clog2(LINES),
    parameter int TAG   = XLEN - 2 - IDX
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            flush_i,
    input  logic [IDX-1:0]  rd_idx_i,
    output logic            rd_valid_o,
    output logic [TAG-1:0]  rd_tag_o,
    output logic [XLEN-1:0] rd_data_o,
    input  logic            wr_en_i,
    input  logic [IDX-1:0]  wr_idx_i,
    input  logic [TAG-1:0]  wr_tag_i,
    input  logic [XLEN-1:0] wr_data_i
);

    logic [LINES-1:0] valid_q;
    logic             rd_valid_q;
    logic [TAG-1:0]   rd_tag_q;
    logic [XLEN-1:0]  rd_data_q;
    logic [TAG-1:0]   tag_mem  [LINES];
    logic [XLEN-1:0]  data_mem [LINES];

    // Flush wins over a same-cycle write so a flushed refill never leaves a valid line.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            valid_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= valid_q[rd_idx_i];
            if (flush_i) begin
                valid_q <= '0;
            end else if (wr_en_i) begin
                valid_q[wr_idx_i] <= 1'b1;
            end
        end
    end

    // Tag/data contents are qualified by the valid bits, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_mem[wr_idx_i]  <= wr_tag_i;
            data_mem[wr_idx_i] <= wr_data_i;
        end
        rd_tag_q  <= tag_mem[rd_idx_i];
        rd_data_q <= data_mem[rd_idx_i];
    end

    assign rd_valid_o = rd_valid_q;
    assign rd_tag_o   = rd_tag_q;
    assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/rv_icache.sv
// rtl/rv_icache.sv - direct-mapped read-only instruction cache, one 32-bit word per line
// Ports: clk_i, arst_i (async, active-high), flush_i (invalidate all, fence.i),
//        core_if (slave: instruction fetch from the core), mem_if (master: refill from flash).
// Macro RV_ICACHE_PREFETCH_EN: after a demand miss, also fetch and fill the next word.
module rv_icache
    import rv_icache_pkg::*;
#(
    parameter int LINES = ICACHE_LINES_DEFAULT
) (
    input  logic       clk_i,
    input  logic       arst_i,
    input  logic       flush_i,
    rv_icache_if.slave  core_if,
    rv_icache_if.master mem_if
);

    localparam int IDX = $clog2(LINES);
    localparam int TAG = XLEN - 2 - IDX;

    icache_state_t    state_q;
    logic [XLEN-3:0]  wa_q;          // latched word address of the current line
    logic             force_miss_q;  // flush arrived together with the accepted request
    logic             no_write_q;    // flush seen while a refill is outstanding
    logic             rvalid_q;
    logic [XLEN-1:0]  rdata_q;
    logic             mem_req_q;
    logic [XLEN-1:0]  mem_addr_q;
`ifdef RV_ICACHE_PREFETCH_EN
    logic             miss_q;
    logic [XLEN-3:0]  wa_next;
`endif

    logic             rd_valid;
    logic [TAG-1:0]   rd_tag;
    logic [XLEN-1:0]  rd_data;
    logic             hit;
    logic             refill_beat;
    logic             wr_en;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^core_if.addr[1:0];

    assign hit = rd_valid && (rd_tag == wa_q[XLEN-3:IDX]) && !force_miss_q && !flush_i;

`ifdef RV_ICACHE_PREFETCH_EN
    assign wa_next     = wa_q + {{(XLEN-3){1'b0}}, 1'b1};
    assign refill_beat = mem_if.rvalid && ((state_q == REFILL) || (state_q == PREFETCH));
`else
    assign refill_beat = mem_if.rvalid && (state_q == REFILL);
`endif
    assign wr_en = refill_beat && !no_write_q && !flush_i;

    // Tag/data are read every cycle at the core's index; the value captured on the
    // accepting edge is what LOOKUP compares against.
    rv_icache_mem #(
        .LINES(LINES)
    ) u_mem (
        .clk_i      (clk_i),
        .arst_i     (arst_i),
        .flush_i    (flush_i),
        .rd_idx_i   (core_if.addr[IDX+1:2]),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data),
        .wr_en_i    (wr_en),
        .wr_idx_i   (wa_q[IDX-1:0]),
        .wr_tag_i   (wa_q[XLEN-3:IDX]),
        .wr_data_i  (mem_if.rdata)
    );

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q      <= IDLE;
            wa_q         <= '0;
            force_miss_q <= 1'b0;
            no_write_q   <= 1'b0;
            rvalid_q     <= 1'b0;
            rdata_q      <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
`ifdef RV_ICACHE_PREFETCH_EN
            miss_q       <= 1'b0;
`endif
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (core_if.req) begin
                        wa_q         <= core_if.addr[XLEN-1:2];
                        force_miss_q <= flush_i;
                        state_q      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        rvalid_q <= 1'b1;
                        rdata_q  <= rd_data;
                        state_q  <= RESP;
`ifdef RV_ICACHE_PREFETCH_EN
                        miss_q   <= 1'b0;
`endif
                    end else begin
                        // A flush on this edge has already cleared the array; the refill
                        // that follows may still fill the line.
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {wa_q, 2'b00};
                        no_write_q <= 1'b0;
                        state_q    <= REFILL;
`ifdef RV_ICACHE_PREFETCH_EN
                        miss_q     <= 1'b1;
`endif
                    end
                end
                REFILL: begin
                    if (flush_i) begin
                        no_write_q <= 1'b1;
                    end
                    if (mem_if.rvalid) begin
                        mem_req_q <= 1'b0;
                        rdata_q   <= mem_if.rdata;
                        rvalid_q  <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
`ifdef RV_ICACHE_PREFETCH_EN
                    // mem_req was low during RESP, so the flash sees a fresh request.
                    if (miss_q) begin
                        wa_q       <= wa_next;
                        mem_addr_q <= {wa_next, 2'b00};
                        mem_req_q  <= 1'b1;
                        no_write_q <= 1'b0;
                        state_q    <= PREFETCH;
                    end else begin
                        state_q <= IDLE;
                    end
`else
                    state_q <= IDLE;
`endif
                end
`ifdef RV_ICACHE_PREFETCH_EN
                PREFETCH: begin
                    if (flush_i) begin
                        no_write_q <= 1'b1;
                    end
                    if (mem_if.rvalid) begin
                        mem_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    assign core_if.rvalid = rvalid_q;
    assign core_if.rdata  = rdata_q;
    assign mem_if.req     = mem_req_q;
    assign mem_if.addr    = mem_addr_q;

endmodule

// File: tb/tb_rv_icache.sv
// tb/tb_rv_icache.sv - randomized scoreboard bench for rv_icache with a behavioural cache model
module tb_rv_icache;

    localparam int LINES = 64;
`ifdef RV_ICACHE_PREFETCH_EN
    localparam int PF = 2;
`else
    localparam int PF = 1;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          lat;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    rv_icache_if #(.XLEN(32)) core_bus ();
    rv_icache_if #(.XLEN(32)) mem_bus ();

    rv_icache #(.LINES(LINES)) dut (
        .clk_i   (clk),
        .arst_i  (rst),
        .flush_i (flush),
        .core_if (core_bus),
        .mem_if  (mem_bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          flash_lat = 3;
    int          mem_count = 0;
    exp_t        sb[$];
    logic [31:0] mem_exp[$];
    bit          mvalid[LINES];
    logic [29:0] mword[LINES];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] flash_word(input logic [31:0] a);
        return a ^ 32'h1234_5778;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> 2) & (LINES - 1));
    endfunction

    task automatic mclear();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endtask

    task automatic mfill(input logic [31:0] a);
        mvalid[line_of(a)] = 1'b1;
        mword[line_of(a)]  = a[31:2];
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Flash model: answers each request after flash_lat cycles, checks the refill address.
    initial begin : flash
        logic [31:0] fa;
        bit          ab;
        mem_bus.rvalid = 1'b0;
        mem_bus.rdata  = '0;
        forever begin
            @(negedge clk);
            if (mem_bus.req && !rst) begin
                fa = mem_bus.addr;
                mem_count++;
                if (mem_exp.size() == 0) check("mem_unexpected_req", 32'd1, 32'd0);
                else check("mem_addr", fa, mem_exp.pop_front());
                ab = 1'b0;
                for (int k = 0; k < flash_lat - 1; k++) begin
                    @(negedge clk);
                    if (rst) begin
                        ab = 1'b1;
                        break;
                    end
                end
                if (!ab) begin
                    mem_bus.rdata  = flash_word(fa);
                    mem_bus.rvalid = 1'b1;
                    @(negedge clk);
                    mem_bus.rvalid = 1'b0;
                end
            end
        end
    end

    // Monitor: every rvalid pulse must match the oldest outstanding expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && core_bus.rvalid) begin
                if (sb.size() == 0) begin
                    check("spurious_rvalid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("resp_data", core_bus.rdata, e.data);
                    if (e.lat >= 0) check("resp_latency", cyc - e.cyc, e.lat);
                end
            end
        end
    end

    task automatic wait_mem_idle();
        int guard = 0;
        while (mem_bus.req && guard < 100) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic flush_idle();
        wait_mem_idle();
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        mclear();
    endtask

    // fmode: 0 none, 1 flush with request, 2 flush during refill, 3 flush during lookup
    task automatic do_req(input logic [31:0] a, input int fmode_in, input int lat, input bit held);
        exp_t        e;
        int          idx;
        bit          hit;
        int          fmode;
        int          guard;
        logic [31:0] pa;
        fmode = fmode_in;
        if (held && (fmode == 1 || fmode == 3)) fmode = 0;
        if (!held) wait_mem_idle();
        flash_lat = lat;
        idx = line_of(a);
        if (fmode == 1 || fmode == 3) mclear();
        hit = mvalid[idx] && (mword[idx] == a[31:2]);
        if (hit && fmode == 2) fmode = 0;
        e.addr = a;
        e.data = flash_word({a[31:2], 2'b00});
        e.lat  = held ? -1 : (hit ? 2 : lat + 2);
        if (!hit) begin
            mem_exp.push_back({a[31:2], 2'b00});
            if (fmode == 2) mclear();
            else mfill(a);
`ifdef RV_ICACHE_PREFETCH_EN
            pa = {a[31:2] + 30'd1, 2'b00};
            mem_exp.push_back(pa);
            mfill(pa);
`else
            pa = '0;
`endif
        end
        core_bus.req  = 1'b1;
        core_bus.addr = a;
        flush = (fmode == 1);
        e.cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        flush = 1'b0;
        if (fmode == 3) begin
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
        if (fmode == 2) begin
            guard = 0;
            while (!mem_bus.req && guard < 100) begin
                @(negedge clk);
                guard++;
            end
            flush = 1'b1;
            @(negedge clk);
            flush = 1'b0;
        end
        guard = 0;
        while (!core_bus.rvalid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!core_bus.rvalid) check("resp_timeout", 32'd0, 32'd1);
        core_bus.req = 1'b0;
        @(negedge clk);
    endtask

    initial begin : main
        int          m0;
        int          guard;
        logic [31:0] bases[4];
        logic [31:0] a;
        int          r;
        bases[0] = 32'h0000_0100;
        bases[1] = 32'h0000_0200;
        bases[2] = 32'h0000_1100;
        bases[3] = 32'hFFFF_FFC0;
        rst = 1'b1;
        flush = 1'b0;
        core_bus.req = 1'b0;
        core_bus.addr = '0;
        mclear();
        repeat (3) @(negedge clk);
        check("reset_rvalid", core_bus.rvalid, 1'b0);
        check("reset_rdata", core_bus.rdata, 32'h0);
        check("reset_mem_req", mem_bus.req, 1'b0);
        check("reset_mem_addr", mem_bus.addr, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Cold miss with 5-cycle flash, then a hit without any refill.
        do_req(32'h0000_0100, 0, 5, 0);
        m0 = mem_count;
        do_req(32'h0000_0100, 0, 3, 0);
        check("hit_no_mem_req", mem_count - m0, 0);

        // Back-to-back hits.
        do_req(32'h0000_0104, 0, 2, 0);
        do_req(32'h0000_0108, 0, 4, 0);
        m0 = mem_count;
        do_req(32'h0000_0100, 0, 3, 0);
        do_req(32'h0000_0104, 0, 3, 0);
        do_req(32'h0000_0108, 0, 3, 0);
        check("b2b_hits_no_mem", mem_count - m0, 0);

        // Conflicting lines at index 0.
        flush_idle();
        m0 = mem_count;
        do_req(32'h0000_0100, 0, 3, 0);
        do_req(32'h0000_0200, 0, 3, 0);
        do_req(32'h0000_0100, 0, 3, 0);
        check("conflict_misses", mem_count - m0, 3 * PF);

        // Flush between fetches, then flush during a refill.
        flush_idle();
        do_req(32'h0000_0100, 0, 2, 0);
        flush_idle();
        m0 = mem_count;
        do_req(32'h0000_0100, 0, 2, 0);
        check("flush_then_miss", mem_count - m0, PF);
        flush_idle();
        do_req(32'h0000_0104, 2, 4, 0);
        m0 = mem_count;
        do_req(32'h0000_0104, 0, 2, 0);
        check("refill_flush_no_fill", mem_count - m0, PF);

        // Reset in the middle of a refill.
        flush_idle();
        flash_lat = 10;
        mem_exp.push_back(32'h0000_0300);
        core_bus.req  = 1'b1;
        core_bus.addr = 32'h0000_0300;
        guard = 0;
        while (!mem_bus.req && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        #2 rst = 1'b1;
        core_bus.req = 1'b0;
        #1;
        check("midrst_rvalid", core_bus.rvalid, 1'b0);
        check("midrst_rdata", core_bus.rdata, 32'h0);
        check("midrst_mem_req", mem_bus.req, 1'b0);
        check("midrst_mem_addr", mem_bus.addr, 32'h0);
        @(negedge clk);
        check("midrst_mem_req_next", mem_bus.req, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        mclear();
        @(negedge clk);
        m0 = mem_count;
        do_req(32'h0000_0100, 0, 3, 0);
        check("post_reset_miss", mem_count - m0, PF);

        // Next-line behaviour, address wrap and a request held behind a prefetch.
        flush_idle();
        do_req(32'h0000_0100, 0, 3, 0);
        m0 = mem_count;
        do_req(32'h0000_0104, 0, 3, 0);
        check("next_line_fetch", mem_count - m0, (PF == 2) ? 0 : 1);
        do_req(32'hFFFF_FFFC, 0, 3, 0);
        do_req(32'h0000_0000, 0, 2, 0);
        do_req(32'h0000_0300, 0, 3, 0);
        do_req(32'h0000_0400, 0, 3, 1);

        // Randomized traffic over a small address pool so hits and conflicts recur.
        for (int i = 0; i < 150; i++) begin
            a = bases[$urandom_range(0, 3)] + 32'($urandom_range(0, 15) * 4);
            r = $urandom_range(0, 19);
            if (r == 0) flush_idle();
            do_req(a, (r < 2) ? 1 : (r < 4) ? 2 : (r < 5) ? 3 : 0,
                   $urandom_range(1, 6), ($urandom_range(0, 7) == 0));
        end

        wait_mem_idle();
        repeat (5) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        check("mem_exp_drained", mem_exp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
